txuart: RTL and testbench
=========================

# txuart

Serial UART transmitter; the transmit-side counterpart of the receiver in the same serial port. It accepts one byte per write strobe and serialises it as start bit, 5–8 data bits (LSB first), optional parity, and one or two stop bits. Frame format and baud rate come from the same 31-bit setup word the receiver uses, so one control register drives both directions. It sits between the bus-side TX FIFO/controller and the `o_uart_tx` pin, with optional CTS flow control and line-break generation.

## Interface
- `INITIAL_SETUP`, 31'd868: setup value loaded at power-up and at reset. Fields are as for `i_setup`. The default gives 8N1 at 868 clocks/baud.
- `i_clk` input 1: sole clock.
- `i_reset` input 1: reset, synchronous and active-high.
- `i_setup` input 31: setup word, fields below.
  - [30]: CTS flow-control enable.
  - [29:28]: data bits; 00=8, 01=7, 10=6, 11=5.
  - [27]: two stop bits.
  - [26]: parity enable.
  - [25]: fixed parity.
  - [24]: parity_even.
  - [23:0]: clocks per baud.
- `i_break` input 1: request line break; hold high for as long as the break is wanted.
- `i_wr` input 1: write strobe; valid with `i_data`.
- `i_data` input 8: byte to send; only the low N bits are used, N = configured data-bit count.
- `i_cts_n` input 1: clear-to-send, active-low, asynchronous. Synchronised internally through 2 flops.
- `o_uart_tx` output 1: serial line, registered. Idle level is 1.
- `o_busy` output 1: high whenever a write would not be accepted.

## Operation
- States use 4-bit encodings:
  - BIT_ZERO..BIT_SEVEN = 0..7
  - PARITY = 8
  - STOP = 9
  - SECOND_STOP = a
  - START = c
  - BREAK = d
  - IDLE = f
- Setup latch:
  - `i_setup` is captured into an internal register only in IDLE, on the cycle a write is accepted.
  - Changes to `i_setup` during a frame are ignored.
  - Reset reloads `INITIAL_SETUP`.
- A write is accepted when all of the following hold: `i_wr`, state==IDLE, `!i_break`, and either CTS is asserted or flow control is disabled.
  - On acceptance: latch the data and setup, then go to START with `o_uart_tx`=0.
  - `i_wr` while `o_busy` is high is ignored and the byte is dropped. No error is flagged.
- START exits to BIT_ZERO (8 bits), BIT_ONE (7), BIT_TWO (6) or BIT_THREE (5).
- Each data state drives the shift-register LSB, then shifts right. States increment through BIT_SEVEN.
- After BIT_SEVEN: go to PARITY if parity is enabled, else STOP.
- PARITY drives one of:
  - fixed parity: bit = parity_even
  - even parity: bit = XOR of the transmitted data bits
  - odd parity: the inverse of even
- STOP drives 1, then goes to SECOND_STOP if two stop bits are set, else IDLE. SECOND_STOP drives 1, then goes to IDLE.
- Baud counter (24 bits):
  - Load clocks_per_baud−1 on entry to every non-IDLE state.
  - Decrement each cycle.
  - The state advances on the cycle the counter reads 0.
  - Every bit therefore lasts exactly clocks_per_baud cycles. clocks_per_baud ≥ 2 is required; smaller values are undefined.
- Break handling:
  - `i_break` high in any state aborts the frame immediately. The state goes to BREAK next cycle and `o_uart_tx`=0.
  - On `i_break` falling, the block goes to STOP, holds 1 for one full baud, then goes to IDLE.
- `o_busy` = (state != IDLE) || `i_break` || (flow control enabled && CTS deasserted).
- CTS is checked only at frame start. Deassertion mid-frame does not stop the current frame.

## Timing
- Reset values:
  - state=IDLE
  - `o_uart_tx`=1
  - `o_busy`=0, unless `i_break` is high or CTS blocks transmission
  - shift register=0
  - setup=`INITIAL_SETUP`
- Reset mid-frame: the line returns to 1 on the next cycle and the frame is truncated.
- Write accepted at edge N:
  - `o_uart_tx` falls and `o_busy` rises, both registered at edge N.
  - Start bit covers edges N..N+C−1, where C = clocks per baud. Bit 0 begins at edge N+C.
- Frame length in cycles: C × (1 + D + P + S), where D = data bits, P = 1 if parity is enabled else 0, and S = stop bits.
- `o_busy` falls at the edge where IDLE is re-entered. A new write is accepted on that same cycle, so back-to-back frames have no idle gap beyond the stop bits.
- `i_break` and `i_wr` high together in IDLE: break wins and the write is dropped.
- CTS path latency: 2 cycles from `i_cts_n` to the internal signal, plus 1 cycle to `o_busy`.

## Test plan
- Setup=868, write 0x55 → `o_uart_tx` reads 0,1,0,1,0,1,0,1,0,1. Each level holds 868 cycles. `o_busy` is high for 8680 cycles.
- Setup with 7 data bits, even parity, two stop bits, C=16; write 0xC3 → bits 0, 1100001 (LSB first), parity 1, stop 1, stop 1. Frame is 176 cycles.
- Fixed parity, parity_even=0, C=4, write 0xFF → parity bit 0.
- Two writes on consecutive IDLE cycles with C=4 → second start bit directly follows first stop bit. A `i_wr` pulsed mid-frame is dropped, with no extra frame.
- `i_break` raised at bit 3 for 100 cycles, C=8 → line is 0 from the next cycle for 100 cycles, then 1 for 8 cycles, then `o_busy` falls.
- Flow control enabled, `i_cts_n`=1, `i_wr` with 0xA5 → no transmission and `o_busy`=1. `i_cts_n`=0, then a new write → frame sent. `i_reset` mid-frame → `o_uart_tx`=1 on the next cycle.

Source files
------------

// File: rtl/txuart.sv
// Serial UART transmitter: start bit, 5-8 data bits LSB first, optional parity,
// one or two stop bits, with CTS flow control and line-break generation.
module txuart #(
  parameter logic [30:0] INITIAL_SETUP = 31'd868
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [30:0] i_setup,
  input  logic        i_break,
  input  logic        i_wr,
  input  logic [7:0]  i_data,
  input  logic        i_cts_n,
  output logic        o_uart_tx,
  output logic        o_busy
);

  typedef enum logic [3:0] {
    BIT_ZERO    = 4'h0,
    BIT_ONE     = 4'h1,
    BIT_TWO     = 4'h2,
    BIT_THREE   = 4'h3,
    BIT_FOUR    = 4'h4,
    BIT_FIVE    = 4'h5,
    BIT_SIX     = 4'h6,
    BIT_SEVEN   = 4'h7,
    PARITY      = 4'h8,
    STOP        = 4'h9,
    SECOND_STOP = 4'ha,
    START       = 4'hc,
    BREAK       = 4'hd,
    IDLE        = 4'hf
  } state_t;

  state_t      r_state;
  logic [29:0] r_setup;
  logic [7:0]  r_data;
  logic [23:0] r_baud;
  logic        r_parity;
  logic        r_tx;
  logic        r_busy;
  logic [1:0]  r_cts_sync;

  logic        w_cts;
  logic        w_cts_ok;
  logic        w_accept;
  logic        w_zero;
  logic        w_parity_bit;
  logic [23:0] w_reload;
  state_t      w_first_bit;

  // Two-flop synchroniser for the asynchronous clear-to-send input.
  always_ff @(posedge i_clk) begin
    r_cts_sync <= {r_cts_sync[0], ~i_cts_n};
  end

  // Flow-control enable is taken live from i_setup so it gates the very
  // write that would latch it.
  assign w_cts        = r_cts_sync[1];
  assign w_cts_ok     = !i_setup[30] || w_cts;
  assign w_accept     = i_wr && (r_state == IDLE) && !i_break && w_cts_ok;
  assign w_zero       = (r_baud == '0);
  assign w_reload     = r_setup[23:0] - 24'd1;
  assign w_parity_bit = r_setup[25] ? r_setup[24] : (r_parity ^ ~r_setup[24]);

  always_comb begin
    w_first_bit = BIT_ZERO;
    case (r_setup[29:28])
      2'b00:   w_first_bit = BIT_ZERO;
      2'b01:   w_first_bit = BIT_ONE;
      2'b10:   w_first_bit = BIT_TWO;
      default: w_first_bit = BIT_THREE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_busy   <= i_break || !w_cts_ok;
      r_data   <= '0;
      r_setup  <= INITIAL_SETUP[29:0];
      r_baud   <= '0;
      r_parity <= 1'b0;
    end else if (i_break) begin
      r_state <= BREAK;
      r_tx    <= 1'b0;
      r_busy  <= 1'b1;
      r_baud  <= w_reload;
    end else if (r_state == IDLE) begin
      r_tx <= 1'b1;
      if (w_accept) begin
        r_state  <= START;
        r_tx     <= 1'b0;
        r_busy   <= 1'b1;
        r_data   <= i_data;
        r_setup  <= i_setup[29:0];
        r_baud   <= i_setup[23:0] - 24'd1;
        r_parity <= 1'b0;
      end else begin
        r_busy <= !w_cts_ok;
      end
    end else if (r_state == BREAK) begin
      r_state <= STOP;
      r_tx    <= 1'b1;
      r_busy  <= 1'b1;
      r_baud  <= w_reload;
    end else if (!w_zero) begin
      r_baud <= r_baud - 24'd1;
    end else begin
      r_baud <= w_reload;
      // Each data state's bit is driven on entry, so the shift happens here.
      case (r_state)
        START: begin
          r_state  <= w_first_bit;
          r_tx     <= r_data[0];
          r_parity <= r_parity ^ r_data[0];
          r_data   <= {1'b0, r_data[7:1]};
        end
        BIT_ZERO, BIT_ONE, BIT_TWO, BIT_THREE, BIT_FOUR, BIT_FIVE, BIT_SIX: begin
          r_state  <= state_t'(r_state + 4'd1);
          r_tx     <= r_data[0];
          r_parity <= r_parity ^ r_data[0];
          r_data   <= {1'b0, r_data[7:1]};
        end
        BIT_SEVEN: begin
          if (r_setup[26]) begin
            r_state <= PARITY;
            r_tx    <= w_parity_bit;
          end else begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end
        end
        PARITY: begin
          r_state <= STOP;
          r_tx    <= 1'b1;
        end
        STOP: begin
          r_tx <= 1'b1;
          if (r_setup[27]) begin
            r_state <= SECOND_STOP;
          end else begin
            r_state <= IDLE;
            r_busy  <= !w_cts_ok;
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= !w_cts_ok;
        end
      endcase
    end
  end

  assign o_uart_tx = r_tx;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_txuart.sv
// Directed bench for txuart: expected line levels are queued per write and
// compared cycle by cycle against the serial output and busy flag.
module tb_txuart;

  logic        i_clk;
  logic        i_reset;
  logic [30:0] i_setup;
  logic        i_break;
  logic        i_wr;
  logic [7:0]  i_data;
  logic        i_cts_n;
  logic        o_uart_tx;
  logic        o_busy;

  int    n_total;
  int    n_pass;
  string phase;
  bit    exp_q[$];

  localparam logic [30:0] SCRAMBLE = 31'h3F00_0003;

  txuart #(.INITIAL_SETUP(31'd868)) dut (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_setup   (i_setup),
    .i_break   (i_break),
    .i_wr      (i_wr),
    .i_data    (i_data),
    .i_cts_n   (i_cts_n),
    .o_uart_tx (o_uart_tx),
    .o_busy    (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s/%s: observed %0h expected %0h", phase, tag, obs, exp);
  endtask

  // Expected frame levels derived from the data byte and setup word.
  task automatic push_frame(input logic [7:0] data, input logic [30:0] setup);
    int   nd;
    logic par;
    nd  = 8 - int'(setup[29:28]);
    par = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      exp_q.push_back(data[i]);
      par = par ^ data[i];
    end
    if (setup[26]) exp_q.push_back(setup[25] ? setup[24] : (setup[24] ? par : ~par));
    exp_q.push_back(1'b1);
    if (setup[27]) exp_q.push_back(1'b1);
  endtask

  // Presents a write for one cycle; i_setup is then disturbed to show the
  // latched copy is used for the rest of the frame.
  task automatic send(input logic [7:0] data, input logic [30:0] setup);
    i_setup = setup;
    i_data  = data;
    i_wr    = 1'b1;
    push_frame(data, setup);
    tick();
    i_wr    = 1'b0;
    i_setup = setup ^ SCRAMBLE;
  endtask

  task automatic expect_bits(input int n, input int c_baud, input int drop_bit);
    bit b;
    for (int k = 0; k < n; k++) begin
      b = 1'b1;
      if (exp_q.size() > 0) b = exp_q.pop_front();
      for (int c = 0; c < c_baud; c++) begin
        chk("tx_bit", 32'(o_uart_tx), 32'(b));
        chk("busy_in_frame", 32'(o_busy), 32'd1);
        if (k == drop_bit && c == 0) begin
          i_wr   = 1'b1;
          i_data = 8'hE7;
        end
        tick();
        i_wr = 1'b0;
      end
    end
  endtask

  task automatic expect_idle(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      chk("idle_tx", 32'(o_uart_tx), 32'd1);
      chk("idle_busy", 32'(o_busy), 32'd0);
      tick();
    end
  endtask

  initial begin
    logic [30:0] s_fc;
    n_total = 0;
    n_pass  = 0;
    i_reset = 1'b1;
    i_setup = 31'd868;
    i_break = 1'b0;
    i_wr    = 1'b0;
    i_data  = 8'h00;
    i_cts_n = 1'b0;

    phase = "reset";
    repeat (3) tick();
    chk("tx", 32'(o_uart_tx), 32'd1);
    chk("busy", 32'(o_busy), 32'd0);
    i_reset = 1'b0;
    tick();

    phase = "8n1_c868";
    send(8'h55, 31'd868);
    expect_bits(10, 868, -1);
    expect_idle(3);

    phase = "7e2_c16";
    send(8'hC3, (31'd1 << 28) | (31'd1 << 27) | (31'd1 << 26) | (31'd1 << 24) | 31'd16);
    expect_bits(11, 16, -1);
    expect_idle(2);

    phase = "fixed_par0";
    send(8'hFF, (31'd1 << 26) | (31'd1 << 25) | 31'd4);
    expect_bits(11, 4, -1);
    expect_idle(1);

    phase = "back_to_back";
    send(8'h3C, 31'd4);
    expect_bits(10, 4, 3);
    chk("gap_busy", 32'(o_busy), 32'd0);
    chk("gap_tx", 32'(o_uart_tx), 32'd1);
    send(8'hA1, 31'd4);
    expect_bits(10, 4, -1);
    expect_idle(12);

    phase = "break_mid";
    send(8'h08, 31'd8);
    expect_bits(4, 8, -1);
    chk("bit3_level", 32'(o_uart_tx), 32'd1);
    exp_q.delete();
    i_break = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      chk("break_tx", 32'(o_uart_tx), 32'd0);
      chk("break_busy", 32'(o_busy), 32'd1);
    end
    i_break = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("post_break_tx", 32'(o_uart_tx), 32'd1);
      chk("post_break_busy", 32'(o_busy), 32'd1);
    end
    tick();
    expect_idle(4);

    phase = "flow_ctl";
    s_fc    = (31'd1 << 30) | 31'd4;
    i_setup = s_fc;
    i_cts_n = 1'b1;
    repeat (3) tick();
    chk("blocked_busy", 32'(o_busy), 32'd1);
    i_data = 8'hA5;
    i_wr   = 1'b1;
    tick();
    i_wr = 1'b0;
    for (int c = 0; c < 8; c++) begin
      chk("blocked_tx", 32'(o_uart_tx), 32'd1);
      chk("blocked_busy_hold", 32'(o_busy), 32'd1);
      tick();
    end
    i_cts_n = 1'b0;
    tick();
    chk("cts_lat1", 32'(o_busy), 32'd1);
    tick();
    chk("cts_lat2", 32'(o_busy), 32'd1);
    tick();
    chk("cts_lat3", 32'(o_busy), 32'd0);
    send(8'hA5, s_fc);
    expect_bits(2, 4, -1);
    i_cts_n = 1'b1;
    expect_bits(2, 4, -1);
    i_reset = 1'b1;
    tick();
    chk("reset_mid_tx", 32'(o_uart_tx), 32'd1);
    chk("reset_mid_busy", 32'(o_busy), 32'd1);
    i_reset = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 6; c++) begin
      tick();
      chk("after_reset_tx", 32'(o_uart_tx), 32'd1);
      chk("after_reset_busy", 32'(o_busy), 32'd1);
    end

    phase = "idle_break_wr";
    i_cts_n = 1'b0;
    repeat (3) tick();
    chk("cts_ok_busy", 32'(o_busy), 32'd0);
    i_break = 1'b1;
    i_wr    = 1'b1;
    i_data  = 8'h00;
    i_setup = 31'd4;
    tick();
    i_wr    = 1'b0;
    i_break = 1'b0;
    chk("brk_tx", 32'(o_uart_tx), 32'd0);
    chk("brk_busy", 32'(o_busy), 32'd1);
    tick();
    // Stop after break uses the setup reloaded by reset, 868 clocks.
    for (int c = 0; c < 868; c++) begin
      chk("reset_setup_stop_tx", 32'(o_uart_tx), 32'd1);
      chk("reset_setup_stop_busy", 32'(o_busy), 32'd1);
      tick();
    end
    expect_idle(10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
